// File: rtl/score_pkg.sv
// Shared constants and helpers for the on-screen score display.
// Glyph geometry, ROM glyph offsets and a single-digit BCD increment.
package score_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    localparam logic [3:0] GLYPH_BLANK = 4'h0;
    localparam logic [3:0] GLYPH_OFS   = 4'h1;

    // Returns {cout, digit}; a 9 with carry-in wraps to 0 and carries out.
    function automatic logic [4:0] bcd_inc(
        input logic [3:0] digit,
        input logic       cin
    );
        if (!cin) begin
            return {1'b0, digit};
        end else if (digit == 4'd9) begin
            return {1'b1, 4'd0};
        end else begin
            return {1'b0, digit + 4'd1};
        end
    endfunction

endpackage

// File: rtl/score_display_ctrl_bcd_counter.sv
// Saturating multi-digit BCD score counter with clear priority.
// Ports: clk, rst_n, clr, inc in; value (registered), value_next (comb), sat out.
module bcd_counter
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    inc,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [4*NUM_DIGITS-1:0] value_next,
    output logic                    sat
);

    logic       sat_next;
    logic       all_nines;
    logic       carry;
    logic [4:0] step;

    always_comb begin
        value_next = value;
        sat_next   = sat;
        all_nines  = 1'b1;
        carry      = 1'b1;
        step       = 5'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            all_nines = all_nines & (value[4*k +: 4] == 4'd9);
        end
        if (clr) begin
            value_next = '0;
            sat_next   = 1'b0;
        end else if (inc) begin
            if (all_nines) begin
                // Hold the maximum rather than wrapping to zero.
                sat_next = 1'b1;
            end else begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    step                = bcd_inc(value[4*k +: 4], carry);
                    value_next[4*k +: 4] = step[3:0];
                    carry               = step[4];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            sat   <= 1'b0;
        end else begin
            value <= value_next;
            sat   <= sat_next;
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Score counter plus 3-stage glyph render pipeline producing pix_on.
// Ports: score_inc/clr, blank_lz, frame_start, pix_valid/x/y, rom_addr/data, pix_on, score_bcd, score_max.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int X0         = 16,
    parameter int Y0         = 16,
    parameter int SCALE_LOG2 = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    score_inc,
    input  logic                    score_clr,
    input  logic                    blank_lz,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [9:0]              pix_x,
    input  logic [9:0]              pix_y,
    output logic [7:0]              rom_addr,
    input  logic [7:0]              rom_data,
    output logic                    pix_on,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic                    score_max
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [9:0] BOX_W = 10'((NUM_DIGITS * GLYPH_W) << SCALE_LOG2);
    localparam logic [9:0] BOX_H = 10'(GLYPH_H << SCALE_LOG2);
    localparam logic [9:0] X0_V  = 10'(X0);
    localparam logic [9:0] Y0_V  = 10'(Y0);

    logic [4*NUM_DIGITS-1:0] score_next;
    logic [4*NUM_DIGITS-1:0] shadow;

    logic [9:0]    rel_x;
    logic [9:0]    rel_y;
    logic          in_box;
    logic [DW-1:0] d;
    logic [DW-1:0] idx;
    logic [2:0]    col;
    logic [3:0]    row;
    logic [3:0]    digit;
    logic          blank_d;
    logic          zero_run;
    logic [3:0]    glyph_sel;

    logic       in_box_d1;
    logic       in_box_d2;
    logic [2:0] col_d1;
    logic [2:0] col_d2;

    bcd_counter #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (score_clr),
        .inc        (score_inc),
        .value      (score_bcd),
        .value_next (score_next),
        .sat        (score_max)
    );

    // Latch the post-update score so a frame never shows a mixed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (frame_start) begin
            shadow <= score_next;
        end
    end

    // Pixels left of / above the box wrap to large values and fail the bound.
    assign rel_x  = pix_x - X0_V;
    assign rel_y  = pix_y - Y0_V;
    assign in_box = pix_valid && (rel_x < BOX_W) && (rel_y < BOX_H);
    assign d      = rel_x[3+SCALE_LOG2 +: DW];
    assign idx    = DW'(NUM_DIGITS - 1) - d;
    assign col    = rel_x[SCALE_LOG2 +: 3];
    assign row    = rel_y[SCALE_LOG2 +: 4];

    // Walk from the MS digit down; zero_run stays set while all digits so far are 0.
    always_comb begin
        zero_run = 1'b1;
        blank_d  = 1'b0;
        digit    = 4'h0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (shadow[4*k +: 4] == 4'h0);
            if (idx == DW'(k)) begin
                digit   = shadow[4*k +: 4];
                blank_d = blank_lz && (k != 0) && zero_run;
            end
        end
    end

    assign glyph_sel = blank_d ? GLYPH_BLANK : (digit + GLYPH_OFS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= 8'h00;
            in_box_d1 <= 1'b0;
            col_d1    <= 3'd0;
            in_box_d2 <= 1'b0;
            col_d2    <= 3'd0;
            pix_on    <= 1'b0;
        end else begin
            rom_addr  <= in_box ? {glyph_sel, row} : 8'h00;
            in_box_d1 <= in_box;
            col_d1    <= col;
            in_box_d2 <= in_box_d1;
            col_d2    <= col_d1;
            pix_on    <= in_box_d2 & rom_data[3'd7 - col_d2];
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomized and directed bench for score_display_ctrl with a behavioural glyph ROM.
// Reference model works on integer scores and pixel arithmetic.
module tb_score_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        score_inc = 1'b0;
    logic        score_clr = 1'b0;
    logic        blank_lz = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        pix_on;
    logic [15:0] score_bcd;
    logic        score_max;

    logic [7:0] rom [256];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    int   m_score = 0;
    bit   m_max = 1'b0;
    int   m_shadow = 0;
    logic [7:0] m_addr = 8'h00;
    bit   h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

    score_display_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .score_inc   (score_inc),
        .score_clr   (score_clr),
        .blank_lz    (blank_lz),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_on      (pix_on),
        .score_bcd   (score_bcd),
        .score_max   (score_max)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit in_box_f(input int x, input int y, input bit v);
        return v && x >= 16 && x < 16 + 64 && y >= 16 && y < 16 + 32;
    endfunction

    function automatic logic [7:0] addr_f(input int x, input int y,
                                          input bit v, input bit blz,
                                          input int sh);
        int d, row, dv, g;
        bit blanked;
        if (!in_box_f(x, y, v)) return 8'h00;
        d = (x - 16) / 16;
        row = ((y - 16) / 2) % 16;
        dv = (sh / pow10(3 - d)) % 10;
        blanked = blz && d < 3 && sh < pow10(3 - d);
        g = blanked ? 0 : dv + 1;
        return 8'(g * 16 + row);
    endfunction

    function automatic bit on_f(input int x, input int y, input bit v,
                                input bit blz, input int sh);
        logic [7:0] a, r;
        int col;
        if (!in_box_f(x, y, v)) return 1'b0;
        a = addr_f(x, y, v, blz, sh);
        r = rom[a];
        col = ((x - 16) / 2) % 8;
        return r[7 - col];
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        logic [15:0] b;
        for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'((s / pow10(i)) % 10);
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_score = 0; m_max = 0; m_shadow = 0;
            m_addr = 8'h00; h0 = 0; h1 = 0; h2 = 0;
        end else begin
            m_addr = addr_f(int'(pix_x), int'(pix_y), pix_valid, blank_lz, m_shadow);
            h2 = h1; h1 = h0;
            h0 = on_f(int'(pix_x), int'(pix_y), pix_valid, blank_lz, m_shadow);
            if (score_clr) begin
                m_score = 0; m_max = 0;
            end else if (score_inc) begin
                if (m_score == 9999) m_max = 1;
                else m_score = m_score + 1;
            end
            if (frame_start) m_shadow = m_score;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rom_addr", int'(rom_addr), int'(m_addr));
            check("model_pix_on", int'(pix_on), int'(h2));
            check("model_score_bcd", int'(score_bcd), int'(to_bcd(m_score)));
            check("model_score_max", int'(score_max), int'(m_max));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input bit v);
        pix_x = 10'(x);
        pix_y = 10'(y);
        pix_valid = v;
    endtask

    task automatic incs(input int n);
        score_inc = 1'b1;
        repeat (n) tick();
        score_inc = 1'b0;
    endtask

    int ox [3] = '{66, 80, 16};
    int oy [3] = '{18, 16, 48};
    bit ov [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        for (int a = 0; a < 256; a++) begin
            rom[a] = (a / 16 == 0 || a % 16 > 9) ? 8'h00 : 8'($urandom);
        end
        rom[8'h31] = 8'h7E;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_score", int'(score_bcd), 0);
        check("reset_addr", int'(rom_addr), 0);

        incs(12);
        check("inc12", int'(score_bcd), 16'h0012);
        score_clr = 1'b1; score_inc = 1'b1;
        tick();
        score_clr = 1'b0; score_inc = 1'b0;
        check("clr_over_inc", int'(score_bcd), 16'h0000);

        incs(99);
        check("score_0099", int'(score_bcd), 16'h0099);
        incs(1);
        check("score_0100", int'(score_bcd), 16'h0100);
        incs(9899);
        check("score_9999", int'(score_bcd), 16'h9999);
        check("max_before_sat", int'(score_max), 0);
        incs(1);
        check("sat_hold", int'(score_bcd), 16'h9999);
        check("sat_flag", int'(score_max), 1);
        score_clr = 1'b1;
        tick();
        score_clr = 1'b0;
        check("clr_score", int'(score_bcd), 0);
        check("clr_max", int'(score_max), 0);

        incs(12);
        blank_lz = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        set_pix(16, 16, 1'b1);
        tick();
        check("addr_blank_ms", int'(rom_addr), 8'h00);
        set_pix(66, 18, 1'b1);
        tick();
        check("addr_digit3", int'(rom_addr), 8'h31);
        set_pix(64, 18, 1'b1);
        tick();
        check("on_blank_ms", int'(pix_on), 0);
        set_pix(66, 18, 1'b1);
        tick();
        check("on_digit3_col1", int'(pix_on), 1);
        tick();
        check("on_digit3_col0", int'(pix_on), 0);

        score_inc = 1'b1;
        tick();
        score_inc = 1'b0;
        tick();
        check("no_tear", int'(rom_addr), 8'h31);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check("new_frame", int'(rom_addr), 8'h41);

        for (int i = 0; i < 3; i++) begin
            set_pix(ox[i], oy[i], ov[i]);
            tick();
            check("oob_addr", int'(rom_addr), 0);
            tick();
            tick();
            check("oob_on", int'(pix_on), 0);
        end

        for (int c = 0; c < 3000; c++) begin
            score_inc = ($urandom % 4) == 0;
            score_clr = ($urandom % 64) == 0;
            frame_start = ($urandom % 16) == 0;
            if (($urandom % 32) == 0) blank_lz = ~blank_lz;
            if (($urandom % 20) == 0) set_pix(int'($urandom % 1024), int'($urandom % 1024), 1'b1);
            else set_pix(int'($urandom_range(0, 100)), int'($urandom_range(0, 60)), ($urandom % 8) != 0);
            tick();
        end

        set_pix(66, 18, 1'b1);
        score_inc = 1'b0; score_clr = 1'b0; frame_start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_on", int'(pix_on), 0);
        check("async_rst_addr", int'(rom_addr), 0);
        check("async_rst_score", int'(score_bcd), 0);
        check("async_rst_max", int'(score_max), 0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int c = 0; c < 500; c++) begin
            score_inc = ($urandom % 3) == 0;
            score_clr = ($urandom % 100) == 0;
            frame_start = ($urandom % 10) == 0;
            set_pix(int'($urandom_range(0, 100)), int'($urandom_range(0, 60)), ($urandom % 8) != 0);
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
